// File: rtl/byte_bus_mem_responder.sv
// Target end of the 8-bit strobed memory bus: byte-wise address/write-data capture, word RAM, strobed read return.
// Optional SYNC_INPUTS_EN adds a two-flop synchronizer in front of the input register stage.
module byte_bus_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       write_enable,
  input  logic       read_enable,
  input  logic       register_enable,
  input  logic       lower_bit,
  input  logic       upper_bit,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       lower_byte_out,
  output logic       upper_byte_out,
  output logic       access_done,
  output logic       protocol_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_WDATA, S_COMMIT, S_FETCH, S_TURN, S_SEND_LO, S_SEND_HI, S_RDONE
  } state_t;

  localparam int unsigned IN_W      = 13;
  localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);

  logic [IN_W-1:0] w_pins;
  logic [IN_W-1:0] r_in;
  logic            w_we, w_re, w_reg, w_lo, w_hi;
  logic [7:0]      w_bus;

  assign w_pins = {write_enable, read_enable, register_enable, lower_bit, upper_bit, bus_in};

`ifdef SYNC_INPUTS_EN
  logic [IN_W-1:0] r_sync1;
  logic [IN_W-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_in    <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      r_in    <= r_sync2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) r_in <= '0;
    else          r_in <= w_pins;
  end
`endif

  assign {w_we, w_re, w_reg, w_lo, w_hi, w_bus} = r_in;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_wd;
  logic [15:0]           r_rd;
  logic                  r_hi_seen;
  logic                  r_is_read, w_go_read;
  logic [3:0]            r_cnt;
  logic                  r_done, w_done;
  logic                  r_perr, w_perr;
  logic                  r_clash;
  logic                  w_ram_we, w_ram_re;
  logic [15:0]           r_ram [0:(1 << ADDR_WIDTH)-1];

  always_comb begin
    w_state_next = r_state;
    w_go_read    = r_is_read;
    w_done       = 1'b0;
    w_perr       = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_re     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_we && w_re) begin
          w_perr = !r_clash;
        end else if ((w_we || w_re) && w_reg) begin
          w_state_next = S_ADDR;
          w_go_read    = w_re;
        end
      end
      S_ADDR: begin
        if (r_is_read) begin
          if (!w_re) begin
            w_perr       = 1'b1;
            w_state_next = S_IDLE;
          end else if (w_hi) begin
            w_state_next = S_FETCH;
          end
        end else if (!w_reg) begin
          w_state_next = S_WDATA;
        end else if (!w_we) begin
          w_perr       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WDATA: begin
        if (!w_we) begin
          if (r_hi_seen) begin
            w_state_next = S_COMMIT;
          end else begin
            w_perr       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_COMMIT: begin
        w_ram_we     = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      S_FETCH: begin
        w_ram_re = 1'b1;
        if (!w_re) begin
          w_perr       = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_TURN;
        end
      end
      S_TURN: begin
        if (!w_re) begin
          w_perr       = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_SEND_LO;
        end
      end
      S_SEND_LO: begin
        if (!w_re) begin
          w_perr       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_next = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (!w_re) begin
          w_perr       = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == HOLD_LAST) begin
          w_state_next = S_RDONE;
        end
      end
      S_RDONE: begin
        if (!w_re) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wd      <= '0;
      r_hi_seen <= 1'b0;
      r_is_read <= 1'b0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_perr    <= 1'b0;
      r_clash   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_is_read <= w_go_read;
      r_done    <= w_done;
      r_perr    <= w_perr;
      // Clash reported once per episode of both enables high, not every cycle.
      r_clash   <= w_we & w_re;
      r_cnt     <= (w_state_next != r_state) ? '0 : r_cnt + 4'd1;
      if (r_state == S_IDLE) r_hi_seen <= 1'b0;
      if (r_state == S_ADDR) begin
        // Only the word-select bits are kept; higher address bits are ignored, so addresses wrap.
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
          if (i < 8) begin
            if (w_lo) r_addr[i] <= w_bus[i[2:0]];
          end else begin
            if (w_hi) r_addr[i] <= w_bus[i[2:0]];
          end
        end
      end
      if (r_state == S_WDATA) begin
        if (w_lo) r_wd[7:0] <= w_bus;
        if (w_hi) begin
          r_wd[15:8] <= w_bus;
          r_hi_seen  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we && reset_n) r_ram[r_addr] <= r_wd;
    if (w_ram_re)            r_rd <= r_ram[r_addr];
  end

  always_comb begin
    bus_out        = '0;
    bus_oe         = 1'b0;
    lower_byte_out = 1'b0;
    upper_byte_out = 1'b0;
    unique case (r_state)
      S_SEND_LO: begin
        bus_oe         = 1'b1;
        bus_out        = r_rd[7:0];
        lower_byte_out = 1'b1;
      end
      S_SEND_HI: begin
        bus_oe         = 1'b1;
        bus_out        = r_rd[15:8];
        upper_byte_out = 1'b1;
      end
      S_RDONE: begin
        bus_oe  = 1'b1;
        bus_out = r_rd[15:8];
      end
      default: ;
    endcase
  end

  assign access_done    = r_done;
  assign protocol_error = r_perr;

endmodule

// File: tb/tb_byte_bus_mem_responder.sv
// Directed and randomized bench for byte_bus_mem_responder against a word-addressed memory model.
module tb_byte_bus_mem_responder;

  localparam int unsigned AW   = 8;
  localparam int unsigned HOLD = 2;
`ifdef SYNC_INPUTS_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic       clk;
  logic       reset_n;
  logic       write_enable, read_enable, register_enable, lower_bit, upper_bit;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe, lower_byte_out, upper_byte_out, access_done, protocol_error;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [int unsigned];
  int unsigned keys [$];

  byte_bus_mem_responder #(.ADDR_WIDTH(AW), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .write_enable(write_enable), .read_enable(read_enable),
    .register_enable(register_enable), .lower_bit(lower_bit), .upper_bit(upper_bit),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .lower_byte_out(lower_byte_out), .upper_byte_out(upper_byte_out),
    .access_done(access_done), .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_pulses(input int n, output int dn, output int pe);
    dn = 0;
    pe = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (access_done === 1'b1)    dn++;
      if (protocol_error === 1'b1) pe++;
    end
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [15:0] d, input bit full);
    int dn, pe;
    @(negedge clk);
    write_enable = 1; register_enable = 1; lower_bit = 1; bus_in = a[7:0];
    repeat (3) @(negedge clk);
    lower_bit = 0; upper_bit = 1; bus_in = a[15:8];
    repeat (3) @(negedge clk);
    upper_bit = 0; register_enable = 0;
    repeat (2) @(negedge clk);
    lower_bit = 1; bus_in = d[7:0];
    repeat (3) @(negedge clk);
    lower_bit = 0;
    if (full) begin
      upper_bit = 1; bus_in = d[15:8];
      repeat (3) @(negedge clk);
      upper_bit = 0;
    end
    write_enable = 0;
    count_pulses(8, dn, pe);
    if (full) begin
      model[a % (1 << AW)] = d;
      chk("wr_done", dn, 1);
      chk("wr_perr", pe, 0);
    end else begin
      chk("short_wr_done", dn, 0);
      chk("short_wr_perr", pe, 1);
    end
  endtask

  // mode 0: full read, 1: drop read_enable at first low strobe, 2: pulse reset at first low strobe
  task automatic read_txn(input logic [15:0] a, input logic [15:0] exp, input int mode);
    int lat, lo_n, hi_n, dn, pe;
    logic seq_ok, stable, fin, rdone_ok;
    logic [7:0] lob, hib;
    lat = -1; lo_n = 0; hi_n = 0; seq_ok = 1; stable = 1; fin = 0; rdone_ok = 0; lob = 0; hib = 0;
    @(negedge clk);
    read_enable = 1; register_enable = 1; lower_bit = 1; bus_in = a[7:0];
    repeat (3) @(negedge clk);
    lower_bit = 0; upper_bit = 1; bus_in = a[15:8];
    for (int i = 1; i <= 40 && !fin; i++) begin
      @(negedge clk);
      if (lower_byte_out === 1'b1) begin
        if (lat < 0) begin
          lat = i;
          lob = bus_out;
        end
        lo_n++;
        if (bus_out !== lob || bus_oe !== 1'b1 || upper_byte_out !== 1'b0) stable = 0;
        if (mode != 0) break;
      end else if (upper_byte_out === 1'b1) begin
        if (hi_n == 0) hib = bus_out;
        hi_n++;
        if (bus_out !== hib || bus_oe !== 1'b1) stable = 0;
      end else if (hi_n > 0) begin
        fin = 1;
        rdone_ok = (bus_oe === 1'b1) && (bus_out === hib);
      end else if (lat > 0 || bus_oe !== 1'b0) begin
        seq_ok = 0;
      end
    end
    read_enable = 0; register_enable = 0; upper_bit = 0;
    if (mode == 2) begin
      reset_n = 0;
      @(negedge clk);
      chk("rst_lat", lat, LAT);
      chk("rst_bus_oe", bus_oe, 0);
      chk("rst_lower", lower_byte_out, 0);
      chk("rst_upper", upper_byte_out, 0);
      chk("rst_bus_out", bus_out, 0);
      reset_n = 1;
      repeat (2) @(negedge clk);
    end else begin
      count_pulses(5, dn, pe);
      chk("rd_oe_release", bus_oe, 0);
      if (mode == 1) begin
        chk("abort_lat", lat, LAT);
        chk("abort_perr", pe, 1);
        chk("abort_done", dn, 0);
      end else begin
        chk("rd_data", {hib, lob}, exp);
        chk("rd_latency", lat, LAT);
        chk("rd_lo_cycles", lo_n, HOLD);
        chk("rd_hi_cycles", hi_n, HOLD);
        chk("rd_oe_turn_gap", seq_ok, 1);
        chk("rd_stable", stable, 1);
        chk("rd_finished", fin, 1);
        chk("rd_rdone_hold", rdone_ok, 1);
        chk("rd_done", dn, 1);
        chk("rd_perr", pe, 0);
      end
    end
  endtask

  initial begin
    int dn, pe, oe_seen;
    int unsigned k;
    logic [15:0] a, d;

    reset_n = 0; write_enable = 0; read_enable = 0; register_enable = 0;
    lower_bit = 0; upper_bit = 0; bus_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_bus_out", bus_out, 0);
    chk("reset_bus_oe", bus_oe, 0);
    chk("reset_lower", lower_byte_out, 0);
    chk("reset_upper", upper_byte_out, 0);
    chk("reset_done", access_done, 0);
    chk("reset_perr", protocol_error, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    write_txn(16'h0012, 16'hBEEF, 1);
    read_txn(16'h0012, 16'hBEEF, 0);

    write_txn(16'h0105, 16'h1234, 1);
    read_txn(16'h0005, 16'h1234, 0);

    write_txn(16'h0012, 16'h5577, 0);
    read_txn(16'h0012, model[16'h0012], 0);

    @(negedge clk);
    write_enable = 1; read_enable = 1; register_enable = 1;
    dn = 0; pe = 0; oe_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin
        write_enable = 0; read_enable = 0; register_enable = 0;
      end
      if (protocol_error === 1'b1) pe++;
      if (access_done === 1'b1) dn++;
      if (bus_oe !== 1'b0) oe_seen++;
    end
    chk("clash_perr", pe, 1);
    chk("clash_done", dn, 0);
    chk("clash_bus_oe", oe_seen, 0);
    read_txn(16'h0005, 16'h1234, 0);

    read_txn(16'h0005, 16'h1234, 1);
    read_txn(16'h0012, 16'hBEEF, 2);
    read_txn(16'h0012, 16'hBEEF, 0);

    for (int n = 0; n < 6; n++) begin
      a = 16'($urandom);
      d = 16'($urandom);
      write_txn(a, d, 1);
      keys.push_back(a % (1 << AW));
    end
    for (int n = 0; n < 6; n++) begin
      k = keys[$urandom_range(0, keys.size() - 1)];
      a = 16'(k + (1 << AW) * $urandom_range(0, 255));
      read_txn(a, model[k], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
